mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit datapath among up to 6 requesters.
- It drives the 3-bit select of the 6:1 datapath mux, so the selected requester's word reaches a single downstream consumer.
- It supports multi-beat bursts (grant is held until the last beat), uses a valid/ready handshake to the consumer, and has a watchdog that reclaims a stalled grant.
- It sits between the requesting units and the shared mux/consumer in the multicycle OTTER datapath.

Parameters:
- N_REQ, 6, number of requesters; legal range 2..6; the mux select encodes 0..N_REQ-1.
- TIMEOUT, 16, consecutive cycles a granted requester may hold req low mid-burst before its grant is revoked; minimum 1.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- req  input  N_REQ  req[i]=1: requester i has a beat to send; req[i] is held until acked.
- last  input  N_REQ  last[i]=1 with req[i]: the current beat is the final beat of i's burst.
- out_ready  input  1  downstream consumer accepts a beat this cycle.
- sel  output  3  select for the 6:1 datapath mux; always in range 0..N_REQ-1.
- gnt  output  N_REQ  one-hot grant; all zero when no grant is held.
- out_valid  output  1  a beat from requester sel is present on the mux output.
- ack  output  N_REQ  one-hot; ack[i]=1 in the cycle requester i's beat is accepted.
- busy  output  1  a grant is held (state GRANT).
- timeout_err  output  1  single-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset (synchronous, RST=1 at the edge) gives:
  - state=IDLE, sel=0, gnt=0, out_valid=0, ack=0, busy=0, timeout_err=0;
  - round-robin pointer ptr=0, watchdog count=0.
  - Reset mid-burst abandons the burst; no ack is issued.
- State IDLE:
  - gnt=0, out_valid=0, busy=0; sel holds its last value.
  - If req is nonzero: winner = first i with req[i]=1, scanning ptr, ptr+1, ... cyclically modulo N_REQ.
  - At the edge: sel<=winner, gnt<=onehot(winner), state<=GRANT, count<=0.
  - Latency from req rising (from IDLE) to gnt asserted: 1 cycle.
- State GRANT:
  - out_valid = req[sel], combinational.
  - ack[sel] = out_valid & out_ready, combinational; all other ack bits are 0.
  - Beat accepted with last[sel]=1: at the edge state<=IDLE, gnt<=0, ptr<=(sel+1) mod N_REQ. The cycle 5 -> 0 wrap is required.
  - Beat accepted with last[sel]=0: grant is held and count<=0.
  - req[sel]=0: count<=count+1. When count reaches TIMEOUT-1 while req[sel] is still 0:
    - at the edge state<=IDLE, gnt<=0, ptr<=(sel+1) mod N_REQ;
    - timeout_err=1 for exactly that next cycle.
  - req[sel]=1 while out_ready=0: this is a stall, not a timeout; count<=0.
  - Requests from other requesters never preempt a held grant.
- Each burst release returns to IDLE for exactly one cycle, so back-to-back bursts from different requesters have a 1-cycle bubble (out_valid=0).
- Fairness: after requester i is released, i has the lowest priority in the next arbitration.
  - With all N_REQ requesting continuously, grants proceed i, i+1, ... and each requester is served once per N_REQ bursts.
- req bits at index >= N_REQ do not exist; sel never takes values >= N_REQ.
- gnt, sel, busy and timeout_err are registered. out_valid and ack are combinational from registered state, req and out_ready.

Test Plan:
- Reset then single requester: RST pulse; req=6'b000100, last=6'b000100, out_ready=1.
  - Next cycle: gnt=6'b000100, sel=2, out_valid=1, ack=6'b000100.
  - Following cycle: gnt=0, busy=0. After reset, gnt=0 and sel=0.
- Round-robin wrap: req=6'b111111 held, last=all 1, out_ready=1 from reset.
  - Grant order is sel=0,1,2,3,4,5,0, each grant separated by one IDLE cycle.
- Burst hold with stall: requester 3 sends 4 beats (last on the 4th); out_ready=0 for 3 cycles after beat 2; req[1]=1 throughout.
  - gnt stays 6'b001000 until the 4th beat is acked; no timeout_err.
  - Next grant goes to requester 1 (sel=1).
- Watchdog: TIMEOUT=16; requester 5 granted, sends 1 non-last beat, then req[5]=0.
  - Exactly 16 cycles after req[5] drops, gnt=0 and timeout_err pulses for 1 cycle.
  - Next arbitration starts the scan at ptr=0.
- Reset mid-burst: requester 4 granted, 2 of 3 beats done, RST=1 for one cycle.
  - Cycle after reset: gnt=0, out_valid=0, busy=0, sel=0.
  - With req=6'b010001 held, requester 0 wins the next arbitration (ptr=0).
- No preemption: requester 2 in a burst; req[0] asserts mid-burst.
  - gnt stays 6'b000100 until last is acked; requester 0 is granted after the single IDLE cycle.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter that drives the select of the shared
// 6:1 datapath mux. It holds a grant across a multi-beat burst, hands
// beats to one consumer with a valid/ready handshake, and reclaims a grant
// whose owner goes quiet mid-burst for too long.
module mux_rr_arbiter #(
  parameter int N_REQ   = 6,   // number of requesters, 2..6
  parameter int TIMEOUT = 16   // idle cycles tolerated mid-burst, >= 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] last,
  input  logic             out_ready,
  output logic [2:0]       sel,
  output logic [N_REQ-1:0] gnt,
  output logic             out_valid,
  output logic [N_REQ-1:0] ack,
  output logic             busy,
  output logic             timeout_err
);

  // The watchdog counter only has to reach TIMEOUT-1 before it fires.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t             state, state_d;
  logic [2:0]         sel_d;
  logic [N_REQ-1:0]   gnt_d;
  logic [2:0]         ptr, ptr_d;
  logic [CNT_W-1:0]   count, count_d;
  logic               timeout_d;

  // Winner of the round-robin scan and helpers about the granted requester.
  logic [2:0]         winner;
  logic [N_REQ-1:0]   winner_onehot;
  logic [2:0]         ptr_after_sel;
  logic               req_sel;
  logic               last_sel;
  logic               beat_acked;

  // gnt is the one-hot of sel while a grant is held and zero in IDLE, so
  // masking with it picks out the granted requester's signals without a
  // variable-index select.
  assign req_sel    = |(req & gnt);
  assign last_sel   = |(last & gnt);
  assign out_valid  = req_sel;
  assign ack        = gnt & req & {N_REQ{out_ready}};
  assign beat_acked = |ack;
  assign busy       = (state == GRANT);

  // Pointer after releasing sel, wrapping from N_REQ-1 back to 0.
  assign ptr_after_sel = (sel == 3'(N_REQ - 1)) ? 3'd0 : sel + 3'd1;

  // Round-robin scan: lowest requesting index at or above ptr, otherwise
  // the lowest requesting index overall (the scan wrapped past N_REQ-1).
  always_comb begin
    winner = 3'd0;
    // The descending loops leave the lowest matching index in winner; the
    // second loop only overrides when something at or above ptr requests.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) winner = 3'(i);
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i] && (3'(i) >= ptr)) winner = 3'(i);
    end
  end

  assign winner_onehot = {{(N_REQ - 1){1'b0}}, 1'b1} << winner;

  // Next-state logic: arbitration in IDLE, burst/stall/watchdog in GRANT.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d   = state;
    sel_d     = sel;
    gnt_d     = gnt;
    ptr_d     = ptr;
    count_d   = count;
    timeout_d = 1'b0;

    unique case (state)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          sel_d   = winner;
          gnt_d   = winner_onehot;
          count_d = '0;
        end
      end

      GRANT: begin
        if (beat_acked) begin
          count_d = '0;
          if (last_sel) begin
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = ptr_after_sel;
          end
        end else if (!req_sel) begin
          // Owner has gone quiet mid-burst: count towards revocation.
          if (count == CNT_W'(TIMEOUT - 1)) begin
            state_d   = IDLE;
            gnt_d     = '0;
            ptr_d     = ptr_after_sel;
            count_d   = '0;
            timeout_d = 1'b1;
          end else begin
            count_d = count + CNT_W'(1);
          end
        end else begin
          // Beat present but consumer stalled: not the owner's fault.
          count_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (RST) begin
      state       <= IDLE;
      sel         <= 3'd0;
      gnt         <= '0;
      ptr         <= 3'd0;
      count       <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      sel         <= sel_d;
      gnt         <= gnt_d;
      ptr         <= ptr_d;
      count       <= count_d;
      timeout_err <= timeout_d;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed stimulus for mux_rr_arbiter. Every beat the
// bench expects to be accepted is queued (requester id) as the stimulus is
// driven; a monitor pops and compares whenever the DUT acks a beat.
module tb_mux_rr_arbiter;

  localparam int N_REQ   = 6;
  localparam int TIMEOUT = 16;

  logic             CLK = 1'b0;
  logic             RST;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] last;
  logic             out_ready;
  logic [2:0]       sel;
  logic [N_REQ-1:0] gnt;
  logic             out_valid;
  logic [N_REQ-1:0] ack;
  logic             busy;
  logic             timeout_err;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  mux_rr_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req         (req),
    .last        (last),
    .out_ready   (out_ready),
    .sel         (sel),
    .gnt         (gnt),
    .out_valid   (out_valid),
    .ack         (ack),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Inputs change 1 time unit after the rising edge; the call returns at the
  // following falling edge, where outputs for that cycle are sampled.
  task automatic cycle(input logic rst, input logic [N_REQ-1:0] r,
                       input logic [N_REQ-1:0] l, input logic rdy);
    @(posedge CLK);
    #1;
    RST       = rst;
    req       = r;
    last      = l;
    out_ready = rdy;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    cycle(1'b1, '0, '0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0);
  endtask

  task automatic sb_drained(input string tag);
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Scoreboard monitor: each acked beat must match the next queued requester.
  always @(negedge CLK) begin
    if (RST === 1'b0 && ack !== '0) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_ack", 32'(ack), 32'd0);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("sb_ack", 32'(ack), 32'(1) << e);
        check("sb_sel", 32'(sel), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; req = '0; last = '0; out_ready = 1'b0;

    // ---- Reset then single requester ----
    do_reset();
    check("rst_gnt", 32'(gnt), 32'h00);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ack", 32'(ack), 32'h00);
    check("rst_terr", 32'(timeout_err), 32'd0);
    exp_q.push_back(2);
    cycle(1'b0, 6'b000100, 6'b000100, 1'b1);
    check("single_idle_gnt", 32'(gnt), 32'h00);
    check("single_idle_valid", 32'(out_valid), 32'd0);
    cycle(1'b0, 6'b000100, 6'b000100, 1'b1);
    check("single_gnt", 32'(gnt), 32'h04);
    check("single_sel", 32'(sel), 32'd2);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_ack", 32'(ack), 32'h04);
    check("single_busy", 32'(busy), 32'd1);
    cycle(1'b0, '0, '0, 1'b1);
    check("single_rel_gnt", 32'(gnt), 32'h00);
    check("single_rel_busy", 32'(busy), 32'd0);
    sb_drained("single_sb_empty");

    // ---- Round-robin wrap with all requesters ----
    do_reset();
    for (int k = 0; k < 7; k++) exp_q.push_back(k % N_REQ);
    for (int k = 0; k < 7; k++) begin
      cycle(1'b0, 6'b111111, 6'b111111, 1'b1);
      check("rr_bubble_busy", 32'(busy), 32'd0);
      check("rr_bubble_valid", 32'(out_valid), 32'd0);
      cycle(1'b0, 6'b111111, 6'b111111, 1'b1);
      check("rr_sel", 32'(sel), 32'(k % N_REQ));
      check("rr_gnt", 32'(gnt), 32'(1) << (k % N_REQ));
    end
    cycle(1'b0, '0, '0, 1'b1);
    check("rr_end_gnt", 32'(gnt), 32'h00);
    sb_drained("rr_sb_empty");

    // ---- Burst hold with stall; requester 1 waits throughout ----
    do_reset();
    repeat (4) exp_q.push_back(3);
    exp_q.push_back(1);
    cycle(1'b0, 6'b001000, 6'b000000, 1'b1);
    cycle(1'b0, 6'b001010, 6'b000000, 1'b1);
    check("burst_b1_gnt", 32'(gnt), 32'h08);
    cycle(1'b0, 6'b001010, 6'b000000, 1'b1);
    check("burst_b2_gnt", 32'(gnt), 32'h08);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 6'b001010, 6'b000000, 1'b0);
      check("stall_gnt", 32'(gnt), 32'h08);
      check("stall_ack", 32'(ack), 32'h00);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_terr", 32'(timeout_err), 32'd0);
    end
    cycle(1'b0, 6'b001010, 6'b000000, 1'b1);
    check("burst_b3_gnt", 32'(gnt), 32'h08);
    cycle(1'b0, 6'b001010, 6'b001000, 1'b1);
    check("burst_b4_gnt", 32'(gnt), 32'h08);
    check("burst_b4_terr", 32'(timeout_err), 32'd0);
    cycle(1'b0, 6'b000010, 6'b000010, 1'b1);
    check("burst_bubble_gnt", 32'(gnt), 32'h00);
    check("burst_bubble_valid", 32'(out_valid), 32'd0);
    cycle(1'b0, 6'b000010, 6'b000010, 1'b1);
    check("burst_next_sel", 32'(sel), 32'd1);
    check("burst_next_gnt", 32'(gnt), 32'h02);
    cycle(1'b0, '0, '0, 1'b1);
    sb_drained("burst_sb_empty");

    // ---- Watchdog revokes a stalled grant ----
    do_reset();
    exp_q.push_back(5);
    cycle(1'b0, 6'b100000, 6'b000000, 1'b1);
    cycle(1'b0, 6'b100000, 6'b000000, 1'b1);
    check("wd_gnt", 32'(gnt), 32'h20);
    for (int t = 0; t < TIMEOUT; t++) begin
      cycle(1'b0, 6'b000000, 6'b000000, 1'b1);
      check("wd_hold_gnt", 32'(gnt), 32'h20);
      check("wd_hold_terr", 32'(timeout_err), 32'd0);
      check("wd_hold_valid", 32'(out_valid), 32'd0);
    end
    exp_q.push_back(0);
    cycle(1'b0, 6'b100001, 6'b100001, 1'b1);
    check("wd_fire_gnt", 32'(gnt), 32'h00);
    check("wd_fire_terr", 32'(timeout_err), 32'd1);
    check("wd_fire_busy", 32'(busy), 32'd0);
    cycle(1'b0, 6'b100001, 6'b100001, 1'b1);
    check("wd_pulse_end", 32'(timeout_err), 32'd0);
    check("wd_next_sel", 32'(sel), 32'd0);
    check("wd_next_gnt", 32'(gnt), 32'h01);
    cycle(1'b0, '0, '0, 1'b1);
    sb_drained("wd_sb_empty");

    // ---- Reset in the middle of a burst ----
    do_reset();
    exp_q.push_back(4);
    exp_q.push_back(4);
    cycle(1'b0, 6'b010000, 6'b000000, 1'b1);
    cycle(1'b0, 6'b010000, 6'b000000, 1'b1);
    cycle(1'b0, 6'b010000, 6'b000000, 1'b1);
    check("mid_gnt", 32'(gnt), 32'h10);
    cycle(1'b1, 6'b010000, 6'b010000, 1'b0);
    exp_q.push_back(0);
    exp_q.push_back(4);
    cycle(1'b0, 6'b010001, 6'b010001, 1'b1);
    check("mid_rst_gnt", 32'(gnt), 32'h00);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sel", 32'(sel), 32'd0);
    check("mid_rst_ack", 32'(ack), 32'h00);
    cycle(1'b0, 6'b010001, 6'b010001, 1'b1);
    check("mid_next_sel", 32'(sel), 32'd0);
    check("mid_next_gnt", 32'(gnt), 32'h01);
    cycle(1'b0, 6'b010000, 6'b010000, 1'b1);
    cycle(1'b0, 6'b010000, 6'b010000, 1'b1);
    check("mid_then4_gnt", 32'(gnt), 32'h10);
    cycle(1'b0, '0, '0, 1'b1);
    sb_drained("mid_sb_empty");

    // ---- No preemption of a held burst ----
    repeat (3) exp_q.push_back(2);
    exp_q.push_back(0);
    cycle(1'b0, 6'b000100, 6'b000000, 1'b1);
    cycle(1'b0, 6'b000100, 6'b000000, 1'b1);
    check("np_b1_gnt", 32'(gnt), 32'h04);
    cycle(1'b0, 6'b000101, 6'b000000, 1'b1);
    check("np_b2_gnt", 32'(gnt), 32'h04);
    cycle(1'b0, 6'b000101, 6'b000100, 1'b1);
    check("np_b3_gnt", 32'(gnt), 32'h04);
    cycle(1'b0, 6'b000001, 6'b000001, 1'b1);
    check("np_bubble_gnt", 32'(gnt), 32'h00);
    check("np_bubble_valid", 32'(out_valid), 32'd0);
    cycle(1'b0, 6'b000001, 6'b000001, 1'b1);
    check("np_next_gnt", 32'(gnt), 32'h01);
    check("np_next_sel", 32'(sel), 32'd0);
    cycle(1'b0, '0, '0, 1'b1);
    sb_drained("np_sb_empty");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
